fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the RISC-V pipeline. It keeps its own shadow of destination-register state for the EX stage and `FWD_DEPTH` later stages. From that shadow it produces per-source forwarding selects for the instruction in EX, plus a hazard-stall request to the front end. It also supports configurable load-data availability, flush, external freeze and a stall-cycle performance counter.

## Interface
- `REG_AW`, 5: register-index width.
- `NUM_SRC`, 2: source operands per instruction (2 or 3); source `i` is bits `[i*REG_AW +: REG_AW]`.
- `FWD_DEPTH`, 2: post-EX stages tracked (2..4); stage 1 = EX/MEM, 2 = MEM/WB, ...
- `LOAD_STAGE`, 2: first post-EX stage at which load data is forwardable (1..`FWD_DEPTH`).
- Localparam `SEL_W = $clog2(FWD_DEPTH+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs` in `NUM_SRC*REG_AW`: ID source indices.
- `id_rd` in `REG_AW`: ID destination.
- `id_regwrite` in 1: ID instruction writes `rd`.
- `id_memtoreg` in 1: ID instruction is a load.
- `ext_stall` in 1: whole-pipeline freeze (e.g. memory wait).
- `flush` in 1: kill the instruction entering EX.
- `cnt_clr` in 1: synchronous clear of `stall_count`.
- `hz_stall` out 1: hold PC and IF/ID; the unit inserts a bubble into EX.
- `ex_valid` out 1: EX shadow entry is valid.
- `ex_fwd_sel` out `NUM_SRC*SEL_W`: per-source select; 0 = register file, k = stage k.
- `stall_count` out 16: saturating count of hazard-stall cycles.

## Operation
- Shadow entry fields: `valid`, `rd`, `regwrite`, `memtoreg`, and (EX entry only) `rs[NUM_SRC]`. Positions: P0 = EX, P1..P`FWD_DEPTH`.
- **Producer match** at position p for source index s: the entry is valid, has `regwrite`=1, `rd`==s, and s!=0. Index 0 never matches.
- **Forwarding (EX)**
  - For each EX source, select the lowest k in 1..`FWD_DEPTH` with a producer match.
  - If there is no match, or P0 is invalid, select 0.
  - Nearest producer always wins.
- **Load-use stall (ID)**
  - For each ID source, with `id_valid`=1, find the nearest match p in 0..`FWD_DEPTH`-1.
  - Stall if that producer has `memtoreg`=1 and p+1 < `LOAD_STAGE`.
  - A nearer non-load match masks an older load.
  - `hz_stall` is the OR over all sources. It is 0 when `id_valid`=0.
- **Advance at rising edge, priority order:**
  - `ext_stall`=1: P1..P`FWD_DEPTH` hold. P0 holds, except that P0 becomes a bubble if `flush`=1.
  - Otherwise P`k` <= P`k-1` for k>=1.
  - P0 <= bubble if `flush` or `hz_stall`, else the ID fields (`valid` = `id_valid`).
  - The oldest entry drops out of the window. The register file is write-before-read, so no tracking is needed beyond `FWD_DEPTH`.
- **Counter**
  - `cnt_clr` has priority and sets the counter to 0.
  - Otherwise it increments when `hz_stall`=1 and `ext_stall`=0, saturating at 16'hFFFF.
- **Reset:** all shadow entries invalid; `stall_count`=0. Hence `hz_stall`=0, `ex_valid`=0, and all `ex_fwd_sel`=0. An asserted reset mid-stall clears the stall immediately.

## Timing
- `ex_fwd_sel` and `ex_valid` depend only on registered state and are valid early in the cycle.
- `hz_stall` is combinational from ID inputs and registered state, with one gate level of compare-and-priority. It must not depend on `flush` or `ext_stall`.
- Load-use penalty for a dependent instruction immediately after a load: `LOAD_STAGE`-1 cycles (1 cycle at default). After the stall the consumer forwards from stage `LOAD_STAGE`.
- Simultaneous `flush` and `hz_stall`: P0 gets a bubble; `hz_stall` still asserts, and the front end resolves priority.
- `stall_count` updates one edge after a qualifying cycle.

## Test plan
- **EX/MEM forwarding:** `add x5`, then `sub x6,x5,x7` (defaults). Next cycle: `ex_fwd_sel[src0]`=1, `src1`=0, `hz_stall`=0.
- **Nearest wins:** `addi x5`, `addi x5`, then `or x8,x5,x5`. Both selects = 1. Insert a nop between the second `addi` and the `or`: both selects = 2.
- **Load-use:** `lw x3` then `add x4,x3,x0`.
  - `hz_stall`=1 for exactly one cycle and `stall_count` 0->1.
  - The add enters EX with `ex_fwd_sel[src0]`=2.
  - With `LOAD_STAGE`=3 and `FWD_DEPTH`=3: 2 stall cycles, then select = 3.
- **x0 and bubbles:** `lw x0` then `add x1,x0,x0` gives no stall and select 0. An instruction with `id_valid`=0 carrying a matching `rs` gives `hz_stall`=0.
- **Freeze/flush:**
  - With `ext_stall`=1 for 3 cycles during a load-use stall, the shadow is frozen and `stall_count` is unchanged.
  - `flush` on a load-use cycle leaves P0 invalid next cycle (`ex_valid`=0).
- **Reset and saturation:**
  - Assert `rst_n`=0 asynchronously mid-stall: `hz_stall` drops before the next edge.
  - Force 65,540 stall cycles: `stall_count`=16'hFFFF. `cnt_clr` -> 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select and load-use hazard unit with EX shadow pipeline
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memtoreg,
  input  logic                      ext_stall,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic                      hz_stall,
  output logic                      ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [15:0]               stall_count
);

  // Shadow positions: index 0 is EX, index k is the k-th stage after EX.
  logic [FWD_DEPTH:0]        sh_valid;
  logic [FWD_DEPTH:0]        sh_regwrite;
  logic [REG_AW-1:0]         sh_rd [FWD_DEPTH+1];
  // The load flag of the oldest position is never consulted, so it is not kept.
  logic [FWD_DEPTH-1:0]      sh_memtoreg;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [NUM_SRC-1:0]        src_stall;

  // A position produces register s when it is a live writer of s; x0 never matches.
  function automatic logic producer_match(
    input logic              v,
    input logic              rw,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] s
  );
    return v && rw && (rd == s) && (s != '0);
  endfunction

  assign ex_valid = sh_valid[0];

  // Per EX source: scan oldest to nearest so the nearest producer is the last one written.
  always_comb begin
    ex_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (sh_valid[0] &&
            producer_match(sh_valid[k], sh_regwrite[k], sh_rd[k], ex_rs[i*REG_AW +: REG_AW])) begin
          ex_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  // Per ID source: the nearest producer decides; it stalls only if it is a load not yet forwardable.
  always_comb begin
    src_stall = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int p = FWD_DEPTH - 1; p >= 0; p--) begin
        if (producer_match(sh_valid[p], sh_regwrite[p], sh_rd[p], id_rs[i*REG_AW +: REG_AW])) begin
          src_stall[i] = sh_memtoreg[p] && ((p + 1) < LOAD_STAGE);
        end
      end
    end
    hz_stall = id_valid && (|src_stall);
  end

  // Shadow advance: freeze holds everything (flush may still kill EX), otherwise shift and load EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid    <= '0;
      sh_regwrite <= '0;
      sh_memtoreg <= '0;
      ex_rs       <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        sh_rd[k] <= '0;
      end
    end else if (ext_stall) begin
      if (flush) begin
        sh_valid[0]    <= 1'b0;
        sh_regwrite[0] <= 1'b0;
        sh_memtoreg[0] <= 1'b0;
      end
    end else begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        sh_valid[k]    <= sh_valid[k-1];
        sh_regwrite[k] <= sh_regwrite[k-1];
        sh_rd[k]       <= sh_rd[k-1];
      end
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sh_memtoreg[k] <= sh_memtoreg[k-1];
      end
      if (flush || hz_stall) begin
        sh_valid[0]    <= 1'b0;
        sh_regwrite[0] <= 1'b0;
        sh_memtoreg[0] <= 1'b0;
        sh_rd[0]       <= '0;
        ex_rs          <= '0;
      end else begin
        sh_valid[0]    <= id_valid;
        sh_regwrite[0] <= id_regwrite;
        sh_memtoreg[0] <= id_memtoreg;
        sh_rd[0]       <= id_rd;
        ex_rs          <= id_rs;
      end
    end
  end

  // Saturating count of stall cycles that actually take effect (not masked by a freeze).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
    end else if (hz_stall && !ext_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit over three depth configurations
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memtoreg;
  logic        ext_stall;
  logic        flush;
  logic        cnt_clr;

  logic        hz_d0, hz_d1, hz_d2;
  logic        ev_d0, ev_d1, ev_d2;
  logic [3:0]  sel_d0, sel_d1;
  logic [5:0]  sel_d2;
  logic [15:0] cnt_d0, cnt_d1, cnt_d2;

  int checks = 0;
  int errors = 0;

  // d0: FWD_DEPTH=2 LOAD_STAGE=2, d1: 3/3, d2: 4/4
  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_STAGE(2)) d0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .ext_stall(ext_stall),
    .flush(flush), .cnt_clr(cnt_clr), .hz_stall(hz_d0), .ex_valid(ev_d0),
    .ex_fwd_sel(sel_d0), .stall_count(cnt_d0));
  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_STAGE(3)) d1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .ext_stall(ext_stall),
    .flush(flush), .cnt_clr(cnt_clr), .hz_stall(hz_d1), .ex_valid(ev_d1),
    .ex_fwd_sel(sel_d1), .stall_count(cnt_d1));
  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(4), .LOAD_STAGE(4)) d2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .ext_stall(ext_stall),
    .flush(flush), .cnt_clr(cnt_clr), .hz_stall(hz_d2), .ex_valid(ev_d2),
    .ex_fwd_sel(sel_d2), .stall_count(cnt_d2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        o_hz  [3];
  logic        o_ev  [3];
  logic [2:0]  o_sel [3][2];
  logic [15:0] o_cnt [3];
  assign o_hz[0] = hz_d0;
  assign o_hz[1] = hz_d1;
  assign o_hz[2] = hz_d2;
  assign o_ev[0] = ev_d0;
  assign o_ev[1] = ev_d1;
  assign o_ev[2] = ev_d2;
  assign o_sel[0][0] = {1'b0, sel_d0[1:0]};
  assign o_sel[0][1] = {1'b0, sel_d0[3:2]};
  assign o_sel[1][0] = {1'b0, sel_d1[1:0]};
  assign o_sel[1][1] = {1'b0, sel_d1[3:2]};
  assign o_sel[2][0] = sel_d2[2:0];
  assign o_sel[2][1] = sel_d2[5:3];
  assign o_cnt[0] = cnt_d0;
  assign o_cnt[1] = cnt_d1;
  assign o_cnt[2] = cnt_d2;

  // Reference model: a list of in-flight instructions per configuration, index 0 = EX.
  int cfg_f [3] = '{2, 3, 4};
  int cfg_l [3] = '{2, 3, 4};
  bit m_v   [3][5];
  bit m_rw  [3][5];
  bit m_ld  [3][5];
  int m_rd  [3][5];
  int m_rs  [3][2];
  int m_cnt [3];

  function automatic void m_reset();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 5; p++) begin
        m_v[c][p] = 0; m_rw[c][p] = 0; m_ld[c][p] = 0; m_rd[c][p] = 0;
      end
      m_rs[c][0] = 0; m_rs[c][1] = 0; m_cnt[c] = 0;
    end
  endfunction

  function automatic bit m_match(int c, int p, int s);
    return m_v[c][p] && m_rw[c][p] && (m_rd[c][p] == s) && (s != 0);
  endfunction

  function automatic int m_sel(int c, int i);
    if (!m_v[c][0]) return 0;
    for (int k = 1; k <= cfg_f[c]; k++)
      if (m_match(c, k, m_rs[c][i])) return k;
    return 0;
  endfunction

  function automatic bit m_hz(int c);
    int s;
    if (!id_valid) return 0;
    for (int i = 0; i < 2; i++) begin
      s = int'(id_rs[i*5 +: 5]);
      for (int p = 0; p < cfg_f[c]; p++) begin
        if (m_match(c, p, s)) begin
          if (m_ld[c][p] && (p + 1 < cfg_l[c])) return 1;
          break;
        end
      end
    end
    return 0;
  endfunction

  function automatic void m_advance();
    bit hz;
    for (int c = 0; c < 3; c++) begin
      hz = m_hz(c);
      if (cnt_clr) m_cnt[c] = 0;
      else if (hz && !ext_stall && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
      if (ext_stall) begin
        if (flush) m_v[c][0] = 0;
      end else begin
        for (int k = cfg_f[c]; k >= 1; k--) begin
          m_v[c][k] = m_v[c][k-1]; m_rw[c][k] = m_rw[c][k-1];
          m_ld[c][k] = m_ld[c][k-1]; m_rd[c][k] = m_rd[c][k-1];
        end
        if (flush || hz) begin
          m_v[c][0] = 0; m_rw[c][0] = 0; m_ld[c][0] = 0;
        end else begin
          m_v[c][0] = id_valid; m_rw[c][0] = id_regwrite; m_ld[c][0] = id_memtoreg;
          m_rd[c][0] = int'(id_rd);
          m_rs[c][0] = int'(id_rs[4:0]); m_rs[c][1] = int'(id_rs[9:5]);
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hz_c%0d", c), 32'(o_hz[c]), 32'(m_hz(c)));
      chk($sformatf("ev_c%0d", c), 32'(o_ev[c]), 32'(m_v[c][0]));
      chk($sformatf("sel0_c%0d", c), 32'(o_sel[c][0]), m_sel(c, 0));
      chk($sformatf("sel1_c%0d", c), 32'(o_sel[c][1]), m_sel(c, 1));
      chk($sformatf("cnt_c%0d", c), 32'(o_cnt[c]), m_cnt[c]);
    end
  endtask

  task automatic cycle(input bit chk_en);
    @(negedge clk);
    if (chk_en) check_all();
    m_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rd, input logic [4:0] rs0,
                        input logic [4:0] rs1, input bit rw, input bit ld);
    id_valid = v; id_rd = rd; id_rs = {rs1, rs0}; id_regwrite = rw; id_memtoreg = ld;
  endtask

  task automatic nops(input int n);
    set_id(0, 0, 0, 0, 0, 0);
    repeat (n) cycle(1);
  endtask

  initial begin
    rst_n = 1'b0; ext_stall = 0; flush = 0; cnt_clr = 0;
    set_id(0, 0, 0, 0, 0, 0);
    m_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    // reset state
    chk("rst_hz", 32'(hz_d0), 0);
    chk("rst_ev", 32'(ev_d0), 0);
    chk("rst_sel", 32'(sel_d0), 0);
    chk("rst_cnt", 32'(cnt_d0), 0);
    check_all();
    rst_n = 1'b1;

    // EX/MEM forwarding: add x5 ; sub x6,x5,x7
    set_id(1, 5, 1, 2, 1, 0); cycle(1);
    set_id(1, 6, 5, 7, 1, 0); #1;
    chk("exmem_hz", 32'(hz_d0), 0);
    cycle(1);
    chk("exmem_sel0", 32'(sel_d0[1:0]), 1);
    chk("exmem_sel1", 32'(sel_d0[3:2]), 0);

    // nearest producer wins
    nops(5);
    set_id(1, 5, 1, 0, 1, 0); cycle(1);
    set_id(1, 5, 2, 0, 1, 0); cycle(1);
    set_id(1, 8, 5, 5, 1, 0); cycle(1);
    chk("near_sel0", 32'(sel_d0[1:0]), 1);
    chk("near_sel1", 32'(sel_d0[3:2]), 1);
    nops(5);
    set_id(1, 5, 1, 0, 1, 0); cycle(1);
    set_id(1, 5, 2, 0, 1, 0); cycle(1);
    nops(1);
    set_id(1, 8, 5, 5, 1, 0); cycle(1);
    chk("gap_sel0", 32'(sel_d0[1:0]), 2);
    chk("gap_sel1", 32'(sel_d0[3:2]), 2);

    // load-use: lw x3 ; add x4,x3,x0
    nops(5);
    set_id(1, 3, 1, 0, 1, 1); cycle(1);
    set_id(1, 4, 3, 0, 1, 0); #1;
    chk("lu_hz_a", 32'(hz_d0), 1);
    chk("lu_hz_a_d1", 32'(hz_d1), 1);
    chk("lu_cnt_a", 32'(cnt_d0), 0);
    cycle(1);
    chk("lu_hz_b", 32'(hz_d0), 0);
    chk("lu_hz_b_d1", 32'(hz_d1), 1);
    chk("lu_cnt_b", 32'(cnt_d0), 1);
    cycle(1);
    chk("lu_sel", 32'(sel_d0[1:0]), 2);
    chk("lu_hz_c_d1", 32'(hz_d1), 0);
    chk("lu_cnt_d1", 32'(cnt_d1), 2);
    cycle(1);
    chk("lu_sel_d1", 32'(sel_d1[1:0]), 3);

    // x0 destination and invalid ID
    nops(5);
    set_id(1, 0, 1, 0, 1, 1); cycle(1);
    set_id(1, 1, 0, 0, 1, 0); #1;
    chk("x0_hz", 32'(hz_d0), 0);
    cycle(1);
    chk("x0_sel", 32'(sel_d0), 0);
    set_id(1, 9, 0, 0, 1, 1); cycle(1);
    set_id(0, 2, 9, 9, 1, 0); #1;
    chk("inv_hz", 32'(hz_d0), 0);
    cycle(1);

    // freeze during a load-use stall
    nops(5);
    set_id(1, 3, 1, 0, 1, 1); cycle(1);
    set_id(1, 4, 3, 0, 1, 0);
    ext_stall = 1;
    for (int n = 0; n < 3; n++) begin
      cycle(1);
      chk("frz_hz", 32'(hz_d0), 1);
      chk("frz_ev", 32'(ev_d0), 1);
      chk("frz_cnt", 32'(cnt_d0), 1);
    end
    ext_stall = 0;
    cycle(1);
    chk("frz_cnt_after", 32'(cnt_d0), 2);

    // flush on a load-use cycle
    nops(5);
    set_id(1, 3, 1, 0, 1, 1); cycle(1);
    set_id(1, 4, 3, 0, 1, 0);
    flush = 1; #1;
    chk("fl_hz", 32'(hz_d0), 1);
    cycle(1);
    flush = 0;
    chk("fl_ev", 32'(ev_d0), 0);
    nops(2);

    // randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      ext_stall = $urandom_range(0, 7) == 0;
      flush     = $urandom_range(0, 9) == 0;
      cnt_clr   = $urandom_range(0, 31) == 0;
      cycle(1);
    end
    ext_stall = 0; flush = 0; cnt_clr = 0;

    // asynchronous reset in the middle of a stall
    nops(5);
    set_id(1, 3, 1, 0, 1, 1); cycle(1);
    set_id(1, 4, 3, 0, 1, 0);
    @(negedge clk);
    check_all();
    chk("ar_hz_pre", 32'(hz_d0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_hz", 32'(hz_d0), 0);
    chk("ar_hz_d2", 32'(hz_d2), 0);
    chk("ar_ev", 32'(ev_d0), 0);
    chk("ar_cnt", 32'(cnt_d0), 0);
    m_reset();
    #1 rst_n = 1'b1;
    m_advance();
    @(posedge clk); #1;
    check_all();

    // saturation of the counter on the deepest configuration
    nops(5);
    cnt_clr = 1; cycle(1); cnt_clr = 0;
    set_id(1, 3, 3, 0, 1, 1);
    repeat (87400) cycle(0);
    chk("sat_cnt", 32'(cnt_d2), 32'h0000_FFFF);
    check_all();
    cnt_clr = 1; cycle(1); cnt_clr = 0;
    chk("clr_cnt", 32'(cnt_d2), 0);
    chk("clr_cnt_d0", 32'(cnt_d0), 0);
    nops(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
